// File: rtl/memory.sv
// ---------------------------------------------------------------------------
// memory
// Single-port register-file memory with one shared address. Reads are
// registered (1-cycle latency) and read-before-write on a same-cycle read and
// write. Out-of-range reads return zero and out-of-range writes are dropped.
// The asynchronous active-low reset clears every word and the read register
// immediately.
// ---------------------------------------------------------------------------
module memory #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] input_data,
    output logic [DATA_WIDTH-1:0] output_data
);

    // DEPTH widened by one bit so that DEPTH == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0] DEPTH_W = DEPTH[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] data_r;
    logic                  in_range_s;
    logic                  wr_en_s;
    logic                  rd_en_s;

    // Decode address range and qualify the enables.
    always_comb begin
        in_range_s = 1'b0;
        wr_en_s    = 1'b0;
        rd_en_s    = 1'b0;
        if ({1'b0, address} < DEPTH_W) begin
            in_range_s = 1'b1;
        end else begin
            in_range_s = 1'b0;
        end
        wr_en_s = mem_write & in_range_s;
        rd_en_s = mem_read;
    end

    // Storage array: cleared on reset, written on a qualified write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (wr_en_s) begin
            mem_r[address] <= input_data;
        end
    end

    // Read register: samples the old word (read-before-write), zero when out
    // of range, holds when no read is requested.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r <= {DATA_WIDTH{1'b0}};
        end else if (rd_en_s) begin
            if (in_range_s) begin
                data_r <= mem_r[address];
            end else begin
                data_r <= {DATA_WIDTH{1'b0}};
            end
        end
    end

    assign output_data = data_r;

endmodule

// File: tb/tb_memory.sv
// ---------------------------------------------------------------------------
// tb_memory
// Directed self-checking bench for memory with default parameters.
// Inputs are driven on the falling edge; output_data is sampled 1 time unit
// after the rising edge.
// ---------------------------------------------------------------------------
module tb_memory;

    logic       clk;
    logic       rst_n;
    logic       mem_read;
    logic       mem_write;
    logic [7:0] address;
    logic [7:0] input_data;
    logic [7:0] output_data;

    int checks_cnt;
    int errors_cnt;

    memory #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(8),
        .DEPTH     (256)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .address    (address),
        .input_data (input_data),
        .output_data(output_data)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_value(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    // One operation: drive on the falling edge, sample after the rising edge,
    // then return the enables to idle on the next falling edge.
    task automatic do_op(input logic rd, input logic wr, input logic [7:0] addr,
                         input logic [7:0] data);
        @(negedge clk);
        mem_read   = rd;
        mem_write  = wr;
        address    = addr;
        input_data = data;
        @(posedge clk);
        #1;
        @(negedge clk);
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [7:0] addr, input logic [7:0] exp);
        @(negedge clk);
        mem_read   = 1'b1;
        mem_write  = 1'b0;
        address    = addr;
        input_data = 8'h00;
        @(posedge clk);
        #1;
        check_value(tag, output_data, exp);
        @(negedge clk);
        mem_read = 1'b0;
    endtask

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        rst_n      = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        address    = 8'h00;
        input_data = 8'h00;

        // Reset state and reset-then-read.
        repeat (2) @(posedge clk);
        #1;
        check_value("reset_out", output_data, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        read_check("rd_after_reset_01", 8'h01, 8'h00);

        // Write then read, and hold after mem_read drops.
        do_op(1'b0, 1'b1, 8'h02, 8'hAA);
        read_check("wr_rd_02", 8'h02, 8'hAA);
        @(posedge clk);
        #1;
        check_value("hold_02", output_data, 8'hAA);
        // Write without read must not disturb output_data.
        do_op(1'b0, 1'b1, 8'h03, 8'h5A);
        check_value("hold_after_write", output_data, 8'hAA);

        // Isolation and address boundaries.
        do_op(1'b0, 1'b1, 8'h00, 8'h55);
        do_op(1'b0, 1'b1, 8'hFF, 8'h3C);
        read_check("isolate_01", 8'h01, 8'h00);
        read_check("bound_00", 8'h00, 8'h55);
        read_check("bound_ff", 8'hFF, 8'h3C);
        read_check("rd_03", 8'h03, 8'h5A);

        // Simultaneous read and write: old data returned, new data stored.
        do_op(1'b0, 1'b1, 8'h10, 8'h11);
        @(negedge clk);
        mem_read   = 1'b1;
        mem_write  = 1'b1;
        address    = 8'h10;
        input_data = 8'h22;
        @(posedge clk);
        #1;
        check_value("rbw_old", output_data, 8'h11);
        @(negedge clk);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        read_check("rbw_new", 8'h10, 8'h22);

        // Idle with toggling address/data: nothing may change.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            address    = 8'($urandom_range(0, 255));
            input_data = 8'($urandom_range(0, 255));
            @(posedge clk);
            #1;
            check_value("idle_hold", output_data, 8'h22);
        end
        read_check("idle_mem_02", 8'h02, 8'hAA);
        read_check("idle_mem_00", 8'h00, 8'h55);
        read_check("idle_mem_ff", 8'hFF, 8'h3C);
        read_check("idle_mem_10", 8'h10, 8'h22);

        // Asynchronous reset between clock edges.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_value("async_rst_out", output_data, 8'h00);
        // Operations attempted while reset is held are blocked.
        mem_read   = 1'b1;
        mem_write  = 1'b1;
        address    = 8'h05;
        input_data = 8'h77;
        @(posedge clk);
        #1;
        check_value("rst_blocks_rd", output_data, 8'h00);
        @(negedge clk);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        rst_n     = 1'b1;
        read_check("post_rst_02", 8'h02, 8'h00);
        read_check("post_rst_05", 8'h05, 8'h00);
        read_check("post_rst_10", 8'h10, 8'h00);
        read_check("post_rst_ff", 8'hFF, 8'h00);

        // First operation after release takes effect on the first edge.
        do_op(1'b0, 1'b1, 8'h80, 8'hC3);
        read_check("post_rst_wr_80", 8'h80, 8'hC3);
        read_check("post_rst_wr_81", 8'h81, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors_cnt, checks_cnt);
        $finish;
    end

endmodule

// File: doc/memory.md
MEMORY -- requirements
Module: memory

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, meaning the width of each storage word and of both data ports.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 8, meaning the width of the address port.
REQ-003 The module SHALL have parameter DEPTH, default 256, meaning the number of words (legal range 1 to 2**ADDR_WIDTH).
REQ-004 The module SHALL have port clk, input, 1 bit, the single clock; all sequential logic is on its rising edge.
REQ-005 The module SHALL have port rst_n, input, 1 bit, the reset; reset is asynchronous and active-low.
REQ-006 The module SHALL have port mem_read, input, 1 bit, the read enable, sampled on the rising clk edge.
REQ-007 The module SHALL have port mem_write, input, 1 bit, the write enable, sampled on the rising clk edge.
REQ-008 The module SHALL have port address, input, ADDR_WIDTH bits, the word address for both read and write.
REQ-009 The module SHALL have port input_data, input, DATA_WIDTH bits, the write data.
REQ-010 The module SHALL have port output_data, output, DATA_WIDTH bits, the registered read data.

Function
REQ-011 Storage SHALL be DEPTH words of DATA_WIDTH bits, single-port, with one shared address.
REQ-012 Write: on a rising clk edge with rst_n=1, mem_write=1 and address<DEPTH, mem[address] SHALL take input_data; all other words SHALL be unchanged.
REQ-013 Read: on a rising clk edge with rst_n=1, mem_read=1 and address<DEPTH, output_data SHALL take mem[address]; read latency is 1 cycle.
REQ-014 When mem_read=0, output_data SHALL hold its previous value; there is no tri-state and no combinational path from inputs to output_data.
REQ-015 When mem_read=1 and mem_write=1 in the same cycle, the write SHALL occur and output_data SHALL return the old contents of that address (read-before-write).
REQ-016 When a read has address>=DEPTH, output_data SHALL become all zeros; when a write has address>=DEPTH, it SHALL be ignored. With the default parameters every address is legal.
REQ-017 When mem_read=0 and mem_write=0, memory and output_data SHALL be unchanged.
REQ-018 Address and data inputs SHALL be don't-care when the enable they serve is 0.

Reset
REQ-019 When rst_n=0, every memory word and output_data SHALL be cleared to 0 immediately, without waiting for a clock edge.
REQ-020 While rst_n=0, reads and writes SHALL be blocked.
REQ-021 Reset release SHALL be synchronous; the first operation SHALL take effect on the first rising clk edge after rst_n goes high.
REQ-022 Reset asserted during an operation SHALL abort that operation; no partial or late write SHALL occur after reset.

Verification
REQ-023 Reset then read: assert rst_n=0, release, read address 0x01 -> output_data=0x00 one cycle later.
REQ-024 Write then read: write 0xAA to 0x02, then read 0x02 -> output_data=0xAA after 1 cycle; output_data holds 0xAA after mem_read drops.
REQ-025 Isolation and boundaries: write 0x55 to 0x00 and 0x3C to 0xFF, read 0x01 -> 0x00, read 0x00 -> 0x55, read 0xFF -> 0x3C.
REQ-026 Simultaneous read and write: with mem[0x10]=0x11, in one cycle read and write 0x22 to 0x10 -> output_data=0x11; the next read returns 0x22.
REQ-027 Asynchronous reset: after the writes above, pulse rst_n low between clock edges -> output_data=0x00 before the next edge; read 0x02 -> 0x00.
REQ-028 Idle: with both enables low for 10 cycles and address/input_data toggling randomly -> memory contents and output_data unchanged.
